// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator for the decode stage.
// Decodes the immediate of a 32-bit instruction for the selected format and
// sign/zero-extends it to XLEN. Beats move over valid/ready on both sides.
// Storage is an output register plus a single skid register, so in_ready
// comes straight from a flop and never depends on out_ready.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous; drops held and incoming beats
//   in_valid   input beat present
//   in_ready   block can take a beat this cycle (= skid register empty)
//   in_mode    0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR zimm, 7 illegal
//   in_inst    raw instruction word
//   in_tag     sideband tag, returned unchanged
//   out_valid  output beat present
//   out_ready  consumer takes the beat this cycle
//   out_imm    extended immediate
//   out_tag    tag of the beat on out_imm
//   out_err    beat had an illegal mode
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_mode,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam logic [2:0] MODE_I   = 3'd1;
  localparam logic [2:0] MODE_S   = 3'd2;
  localparam logic [2:0] MODE_B   = 3'd3;
  localparam logic [2:0] MODE_U   = 3'd4;
  localparam logic [2:0] MODE_J   = 3'd5;
  localparam logic [2:0] MODE_Z   = 3'd6;
  localparam logic [2:0] MODE_ILL = 3'd7;

  // Every format is first assembled as a signed 32-bit value; widening that
  // to XLEN then replicates bit 31 (zimm is built with a zero top bit, so it
  // stays zero-extended). R and illegal modes yield 0.
  function automatic logic [XLEN-1:0] gen_imm(input logic [2:0]  mode,
                                              input logic [31:0] inst);
    logic signed [31:0] imm32;
    imm32 = '0;
    case (mode)
      MODE_I: imm32 = {{20{inst[31]}}, inst[31:20]};
      MODE_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      MODE_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                       inst[11:8], 1'b0};
      MODE_U: imm32 = {inst[31:12], 12'b0};
      MODE_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                       inst[30:21], 1'b0};
      MODE_Z: imm32 = {27'b0, inst[19:15]};
      default: imm32 = '0;
    endcase
    return XLEN'(imm32);
  endfunction

  logic             acc_p0;
  logic             err_p0;
  logic [XLEN-1:0]  imm_p0;

  logic             vld_p1;
  logic             err_p1;
  logic [XLEN-1:0]  imm_p1;
  logic [TAG_W-1:0] tag_p1;
  logic             xfer_p1;

  logic             sk_vld_p1;
  logic             sk_err_p1;
  logic [XLEN-1:0]  sk_imm_p1;
  logic [TAG_W-1:0] sk_tag_p1;

  // ---- stage 0: combinational decode and handshake ----
  assign imm_p0   = gen_imm(in_mode, in_inst);
  assign err_p0   = (in_mode == MODE_ILL);
  assign in_ready = !sk_vld_p1;
  assign acc_p0   = in_valid && in_ready;
  assign xfer_p1  = vld_p1 && out_ready;

  // ---- stage 1: output register and skid register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      sk_vld_p1 <= 1'b0;
      imm_p1    <= '0;
      tag_p1    <= '0;
      err_p1    <= 1'b0;
    end else if (flush) begin
      vld_p1    <= 1'b0;
      sk_vld_p1 <= 1'b0;
    end else if (!vld_p1 || xfer_p1) begin
      // Output slot frees up: the older skid beat always wins over a new one.
      if (sk_vld_p1) begin
        vld_p1    <= 1'b1;
        imm_p1    <= sk_imm_p1;
        tag_p1    <= sk_tag_p1;
        err_p1    <= sk_err_p1;
        sk_vld_p1 <= 1'b0;
      end else if (acc_p0) begin
        vld_p1 <= 1'b1;
        imm_p1 <= imm_p0;
        tag_p1 <= in_tag;
        err_p1 <= err_p0;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (acc_p0) begin
      sk_vld_p1 <= 1'b1;
    end
  end

  // Skid payload: an accept implies the skid slot is empty, so capturing on
  // every accept is harmless; sk_vld_p1 decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (acc_p0) begin
      sk_imm_p1 <= imm_p0;
      sk_tag_p1 <= in_tag;
      sk_err_p1 <= err_p0;
    end
  end

  assign out_valid = vld_p1;
  assign out_imm   = imm_p1;
  assign out_tag   = tag_p1;
  assign out_err   = err_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_mode = 3'd0;
  logic [31:0] in_inst = 32'd0;
  logic [4:0]  in_tag = 5'd0;
  logic        out_ready = 1'b1;

  logic        rdy32, vld32, err32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic        rdy64, vld64, err64;
  logic [63:0] imm64;
  logic [4:0]  tag64;

  int checks = 0;
  int errors = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_mode(in_mode),
    .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
    .out_tag(tag32), .out_err(err32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_mode(in_mode),
    .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
    .out_tag(tag64), .out_err(err64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Control and sideband checked on both widths at once.
  task automatic chk_ctl(input string name, input logic vld,
                         input logic rdy, input logic [4:0] tag,
                         input logic err);
    chk({name, " vld32"}, 64'(vld32), 64'(vld));
    chk({name, " vld64"}, 64'(vld64), 64'(vld));
    chk({name, " rdy32"}, 64'(rdy32), 64'(rdy));
    chk({name, " rdy64"}, 64'(rdy64), 64'(rdy));
    if (vld) begin
      chk({name, " tag32"}, 64'(tag32), 64'(tag));
      chk({name, " tag64"}, 64'(tag64), 64'(tag));
      chk({name, " err32"}, 64'(err32), 64'(err));
      chk({name, " err64"}, 64'(err64), 64'(err));
    end
  endtask

  // One beat with out_ready=1; result must be on out_* right after its edge.
  task automatic send(input string name, input logic [2:0] mode,
                      input logic [31:0] inst, input logic [4:0] tag,
                      input logic [31:0] e32, input logic [63:0] e64,
                      input logic eerr);
    in_valid = 1'b1; in_mode = mode; in_inst = inst; in_tag = tag;
    step();
    in_valid = 1'b0; in_inst = 32'hDEAD_BEEF; in_mode = 3'd1;
    chk_ctl(name, 1'b1, 1'b1, tag, eerr);
    chk({name, " imm32"}, 64'(imm32), 64'(e32));
    chk({name, " imm64"}, imm64, e64);
  endtask

  task automatic offer(input logic [2:0] mode, input logic [31:0] inst,
                       input logic [4:0] tag);
    in_valid = 1'b1; in_mode = mode; in_inst = inst; in_tag = tag;
  endtask

  initial begin
    // Reset is asynchronous: outputs must clear with no clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst imm32", 64'(imm32), 64'd0);
    chk("rst imm64", imm64, 64'd0);
    chk_ctl("rst", 1'b0, 1'b1, 5'd0, 1'b0);
    chk("rst tag64", 64'(tag64), 64'd0);
    chk("rst err64", 64'(err64), 64'd0);
    step(); step();
    #2 rst = 1'b0;
    step();
    chk_ctl("idle", 1'b0, 1'b1, 5'd0, 1'b0);

    // Back-to-back beats, one per cycle.
    send("I", 3'd1, 32'hFFF0_0093, 5'd1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send("S", 3'd2, 32'hFE21_AE23, 5'd2, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send("B", 3'd3, 32'hFE00_0CE3, 5'd3, 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    send("U", 3'd4, 32'h8000_00B7, 5'd4, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    send("J", 3'd5, 32'h0010_006F, 5'd5, 32'h0000_0800, 64'h0000_0000_0000_0800, 1'b0);
    send("Jneg", 3'd5, 32'h8000_006F, 5'd6, 32'hFFF0_0000, 64'hFFFF_FFFF_FFF0_0000, 1'b0);
    send("R", 3'd0, 32'hFFFF_FFFF, 5'd7, 32'h0, 64'h0, 1'b0);
    send("Z", 3'd6, 32'h000F_D073, 5'd8, 32'h1F, 64'h1F, 1'b0);
    send("Zhi", 3'd6, 32'hFFFF_FFFF, 5'd9, 32'h1F, 64'h1F, 1'b0);
    send("ILL", 3'd7, 32'hFFFF_FFFF, 5'd21, 32'h0, 64'h0, 1'b1);
    step();
    chk_ctl("drain", 1'b0, 1'b1, 5'd0, 1'b0);

    // Backpressure: tags 1,2 taken, 3 held until the stall clears.
    out_ready = 1'b0;
    offer(3'd1, 32'h0010_0093, 5'd1);
    step();
    chk_ctl("bp t1", 1'b1, 1'b1, 5'd1, 1'b0);
    chk("bp t1 imm", 64'(imm32), 64'h1);
    offer(3'd1, 32'h0020_0093, 5'd2);
    step();
    chk_ctl("bp t2", 1'b1, 1'b0, 5'd1, 1'b0);
    chk("bp hold imm", 64'(imm32), 64'h1);
    offer(3'd1, 32'h0030_0093, 5'd3);
    step();
    chk_ctl("bp t3 held", 1'b1, 1'b0, 5'd1, 1'b0);
    out_ready = 1'b1;
    step();
    chk_ctl("bp out2", 1'b1, 1'b1, 5'd2, 1'b0);
    chk("bp out2 imm", 64'(imm32), 64'h2);
    step();
    in_valid = 1'b0;
    chk_ctl("bp out3", 1'b1, 1'b1, 5'd3, 1'b0);
    chk("bp out3 imm", 64'(imm32), 64'h3);
    step();
    chk_ctl("bp done", 1'b0, 1'b1, 5'd0, 1'b0);

    // Flush with OR and SK full plus an offered beat.
    out_ready = 1'b0;
    offer(3'd1, 32'h0040_0093, 5'd4);
    step();
    offer(3'd1, 32'h0050_0093, 5'd5);
    step();
    chk_ctl("fl full", 1'b1, 1'b0, 5'd4, 1'b0);
    offer(3'd1, 32'h0060_0093, 5'd6);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk_ctl("fl both", 1'b0, 1'b1, 5'd0, 1'b0);
    out_ready = 1'b1;
    step();
    chk_ctl("fl gone", 1'b0, 1'b1, 5'd0, 1'b0);

    // Flush with only OR full: the beat that could be accepted is dropped.
    out_ready = 1'b0;
    offer(3'd1, 32'h0070_0093, 5'd7);
    step();
    offer(3'd1, 32'h0080_0093, 5'd8);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk_ctl("fl acc", 1'b0, 1'b1, 5'd0, 1'b0);
    out_ready = 1'b1;
    step(); step();
    chk_ctl("fl acc gone", 1'b0, 1'b1, 5'd0, 1'b0);

    // Asynchronous reset mid-cycle with OR and SK full.
    out_ready = 1'b0;
    offer(3'd7, 32'h1234_5678, 5'd9);
    step();
    offer(3'd1, 32'hFFF0_0093, 5'd10);
    step();
    in_valid = 1'b0;
    chk_ctl("ar full", 1'b1, 1'b0, 5'd9, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_ctl("ar now", 1'b0, 1'b1, 5'd0, 1'b0);
    chk("ar tag", 64'(tag64), 64'd0);
    chk("ar err", 64'(err64), 64'd0);
    chk("ar imm", imm64, 64'd0);
    step();
    #2 rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk_ctl("ar after", 1'b0, 1'b1, 5'd0, 1'b0);
    send("ar S", 3'd2, 32'hFE21_AE23, 5'd11, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    step();
    chk_ctl("ar end", 1'b0, 1'b1, 5'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
